// File: rtl/tc_pkg.sv
// tc_pkg: shared sizing helpers for the TC buffering blocks
package tc_pkg;
    function automatic int tc_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
    function automatic int tc_ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction
endpackage

// File: rtl/tc_delay_queue_if.sv
// tc_delay_queue_if: save/load handshake and status of the delay-line capture queue
interface tc_delay_queue_if
    import tc_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH = 8
) ();
    logic                         save;
    logic [BIT_WIDTH-1:0]         save_value;
    logic                         load;
    logic                         clr_err;
    logic [BIT_WIDTH-1:0]         out;
    logic [tc_cnt_w(DEPTH)-1:0]   count;
    logic                         empty;
    logic                         full;
    logic                         err;
    modport master (output save, save_value, load, clr_err, input out, count, empty, full, err);
    modport slave  (input save, save_value, load, clr_err, output out, count, empty, full, err);
endinterface

// File: rtl/tc_wrap_ptr.sv
// tc_wrap_ptr: modulo-DEPTH pointer, relies on DEPTH being a power of two
module tc_wrap_ptr
    import tc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inc,
    output logic [tc_ptr_w(DEPTH)-1:0] ptr
);
    localparam int PW = tc_ptr_w(DEPTH);
    always_ff @(posedge clk or negedge rst)
        if (!rst) ptr <= '0;
        else if (inc) ptr <= ptr + PW'(1);
endmodule

// File: rtl/tc_delay_queue.sv
// tc_delay_queue: FIFO capturing delay-line words on save and replaying them on load
module tc_delay_queue
    import tc_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH = 8
) (
    input logic               clk,
    input logic               rst,
    tc_delay_queue_if.slave   q
);
    localparam int CW = tc_cnt_w(DEPTH);
    localparam int PW = tc_ptr_w(DEPTH);
    logic [BIT_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic                 push_ok, pop_ok, rejected;
    logic [CW-1:0]        count_nxt;
    // a full queue still accepts a push when a pop frees the oldest slot the same cycle
    always_comb begin
        push_ok   = q.save & (~q.full | q.load);
        pop_ok    = q.load & ~q.empty;
        rejected  = (q.save & ~push_ok) | (q.load & ~pop_ok);
        count_nxt = q.count + CW'(push_ok) - CW'(pop_ok);
    end
    tc_wrap_ptr #(.DEPTH(DEPTH)) u_wr (.clk(clk), .rst(rst), .inc(push_ok), .ptr(wr_ptr));
    tc_wrap_ptr #(.DEPTH(DEPTH)) u_rd (.clk(clk), .rst(rst), .inc(pop_ok), .ptr(rd_ptr));
    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= q.save_value;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            q.out   <= '0;
            q.count <= '0;
            q.empty <= 1'b1;
            q.full  <= 1'b0;
            q.err   <= 1'b0;
        end else begin
            if (pop_ok) q.out <= mem[rd_ptr];
            q.count <= count_nxt;
            q.empty <= count_nxt == '0;
            q.full  <= count_nxt == CW'(DEPTH);
            q.err   <= rejected | (q.err & ~q.clr_err);
        end
endmodule

// File: tb/tb_tc_delay_queue.sv
// tb_tc_delay_queue: directed and random stimulus checked against a queue-based model
module tb_tc_delay_queue;
    localparam int W = 8;
    localparam int D = 8;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [W-1:0] mq [$];
    logic [W-1:0] out_m = '0;
    logic         err_m = 1'b0;
    tc_delay_queue_if #(.BIT_WIDTH(W), .DEPTH(D)) q ();
    tc_delay_queue #(.BIT_WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .q(q));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic chk_all(input string tag);
        chk({tag, ".out"}, int'(q.out), int'(out_m));
        chk({tag, ".count"}, int'(q.count), mq.size());
        chk({tag, ".empty"}, int'(q.empty), int'(mq.size() == 0));
        chk({tag, ".full"}, int'(q.full), int'(mq.size() == D));
        chk({tag, ".err"}, int'(q.err), int'(err_m));
    endtask
    task automatic cyc(input logic s, input logic [W-1:0] v, input logic l, input logic c, input string tag);
        bit push_ok, pop_ok;
        @(negedge clk);
        q.save = s; q.save_value = v; q.load = l; q.clr_err = c;
        @(posedge clk);
        push_ok = s && (mq.size() < D || l);
        pop_ok  = l && mq.size() > 0;
        if (pop_ok) out_m = mq.pop_front();
        if (push_ok) mq.push_back(v);
        err_m = ((s && !push_ok) || (l && !pop_ok)) ? 1'b1 : (c ? 1'b0 : err_m);
        #1 chk_all(tag);
    endtask
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        mq.delete(); out_m = '0; err_m = 1'b0;
        #1 chk_all(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask
    initial begin
        q.save = 0; q.save_value = '0; q.load = 0; q.clr_err = 0;
        #12 chk_all("reset");
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1, W'($urandom), 0, 0, "pre_push");
        cyc(0, '0, 1, 0, "pre_pop");
        do_reset("mid_reset");
        cyc(0, '0, 1, 0, "pop_after_reset");
        cyc(0, '0, 0, 1, "clr1");
        for (int i = 0; i < D; i++) cyc(1, W'(8'h11 + i), 0, 0, "fill");
        for (int i = 0; i < D; i++) cyc(0, '0, 1, 0, "drain");
        for (int i = 0; i < D; i++) cyc(1, W'($urandom), 0, 0, "fill2");
        cyc(1, 8'hAA, 0, 0, "overflow");
        for (int i = 0; i < D; i++) cyc(0, '0, 1, 0, "drain2");
        cyc(0, '0, 0, 1, "clr2");
        for (int i = 0; i < D; i++) cyc(1, W'($urandom), 0, 0, "fill3");
        cyc(1, 8'hBB, 1, 0, "sim_full");
        for (int i = 0; i < D; i++) cyc(0, '0, 1, 0, "drain3");
        chk("bb_last", int'(q.out), 8'hBB);
        cyc(1, 8'h5C, 1, 0, "sim_empty");
        cyc(0, '0, 1, 0, "pop_5c");
        chk("out_5c", int'(q.out), 8'h5C);
        for (int i = 0; i < 20; i++) begin
            cyc(1, W'($urandom), 0, 0, "wrap_push");
            cyc(0, '0, 1, 0, "wrap_pop");
        end
        cyc(0, '0, 0, 1, "clr3");
        chk("err_cleared", int'(q.err), 0);
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), "random");
        cyc(1, 8'h3C, 0, 1, "set_wins");
        do_reset("final_reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
